banked_regfile: RTL and testbench

Parametrised register file with a hardware context stack: every architectural register marked as banked has one copy per stack level. An interrupt-entry push switches reads and writes to a fresh, zeroed bank, and an exit pop returns to the previous bank untouched. It sits in the core's decode/writeback path in place of the flat two-read, one-write register file and is driven by the interrupt controller's entry/exit strobes.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_stack_ctrl.sv | 43 ++++
 rtl/banked_regfile.sv | 95 +++++++++
 tb/tb_banked_regfile.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, index typedefs and the banked/shared register decode
// used by the banked register file.
package regfile_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int LEVELS_DEF = 4;
  // Upper bound on DEPTH; masks are zero-extended to this width for decode
  localparam int MASK_W     = 1024;

  typedef logic [$clog2(DEPTH_DEF)-1:0]  addr_t;
  typedef logic [$clog2(LEVELS_DEF)-1:0] level_t;

  // Register 0 is hardwired to zero and is never banked
  function automatic logic is_banked(input logic [MASK_W-1:0] mask, input int unsigned r);
    return (r != 0) && mask[r[$clog2(MASK_W)-1:0]];
  endfunction

endpackage

// File: rtl/regfile_stack_ctrl.sv
// Context stack controller: level counter, full/empty decode, push/pop
// acceptance, sticky misuse flag and the valid-clear strobe for a new level.
module regfile_stack_ctrl #(
  parameter  int LEVELS = 4,
  localparam int LW     = $clog2(LEVELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty,
  output logic              err,
  output logic [LEVELS-1:0] clr
);

  logic push_ok, pop_ok, misuse;

  assign full    = (level == LW'(LEVELS - 1));
  assign empty   = (level == '0);
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign misuse  = (push & pop) | (push & full) | (pop & empty);

  // Only the level being entered loses its valid bits
  always_comb begin
    clr = '0;
    if (push_ok) clr[level + 1'b1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      err   <= 1'b0;
    end else begin
      if (push_ok)     level <= level + 1'b1;
      else if (pop_ok) level <= level - 1'b1;
      if (misuse)      err   <= 1'b1;
    end
  end

endmodule

// File: rtl/banked_regfile.sv
// Two-read, one-write register file with per-level banked registers.
// Optional same-cycle write forwarding is enabled by REGFILE_BYPASS_EN.
module banked_regfile
  import regfile_pkg::*;
#(
  parameter  int               WIDTH     = WIDTH_DEF,
  parameter  int               DEPTH     = DEPTH_DEF,
  parameter  int               LEVELS    = LEVELS_DEF,
  parameter  logic [DEPTH-1:0] BANK_MASK = DEPTH'(32'hFFFF_FFFE),
  localparam int               AW        = $clog2(DEPTH),
  localparam int               LW        = $clog2(LEVELS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [AW-1:0]    i_a_addr,
  input  logic [AW-1:0]    i_b_addr,
  input  logic             i_w_ena,
  input  logic [AW-1:0]    i_w_addr,
  input  logic [WIDTH-1:0] i_w_data,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_a_data,
  output logic [WIDTH-1:0] o_b_data,
  output logic [LW-1:0]    o_level,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  localparam logic [MASK_W-1:0] MASK_EXT = MASK_W'(BANK_MASK);

  logic [LEVELS-1:0]           clr;
  logic [DEPTH-1:0][WIDTH-1:0] cur;

  regfile_stack_ctrl #(.LEVELS(LEVELS)) u_ctrl (
    .clk   (i_clk),
    .rst_n (i_reset),
    .push  (i_push),
    .pop   (i_pop),
    .level (o_level),
    .full  (o_full),
    .empty (o_empty),
    .err   (o_err),
    .clr   (clr)
  );

  assign cur[0] = '0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_reg
    logic we;
    assign we = i_w_ena && (i_w_addr == AW'(r));

    if (is_banked(MASK_EXT, r)) begin : g_banked
      logic [WIDTH-1:0]  q [LEVELS];
      logic [LEVELS-1:0] v;

      // Write targets the pre-edge level; clear targets the level being entered
      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          for (int l = 0; l < LEVELS; l++) q[l] <= '0;
          v <= '0;
        end else begin
          v <= v & ~clr;
          if (we) begin
            q[o_level] <= i_w_data;
            v[o_level] <= 1'b1;
          end
        end
      end

      assign cur[r] = v[o_level] ? q[o_level] : '0;
    end else begin : g_shared
      logic [WIDTH-1:0] q;

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)  q <= '0;
        else if (we)   q <= i_w_data;
      end

      assign cur[r] = q;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_a, fwd_b;
  assign fwd_a    = i_w_ena && (i_w_addr == i_a_addr) && (i_a_addr != '0);
  assign fwd_b    = i_w_ena && (i_w_addr == i_b_addr) && (i_b_addr != '0);
  assign o_a_data = fwd_a ? i_w_data : cur[i_a_addr];
  assign o_b_data = fwd_b ? i_w_data : cur[i_b_addr];
`else
  assign o_a_data = cur[i_a_addr];
  assign o_b_data = cur[i_b_addr];
`endif

endmodule

// File: tb/tb_banked_regfile.sv
// Directed scoreboard bench for banked_regfile (registers 1-3 banked, rest shared).
module tb_banked_regfile;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [4:0]  i_a_addr = '0, i_b_addr = '0, i_w_addr = '0;
  logic        i_w_ena = 1'b0, i_push = 1'b0, i_pop = 1'b0;
  logic [31:0] i_w_data = '0;
  logic [31:0] o_a_data, o_b_data;
  logic [1:0]  o_level;
  logic        o_full, o_empty, o_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'd77;
`else
  localparam logic [31:0] BYP_EXP = 32'd0;
`endif

  banked_regfile #(.WIDTH(32), .DEPTH(32), .LEVELS(4), .BANK_MASK(32'h0000_000E)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_a_addr(i_a_addr), .i_b_addr(i_b_addr),
    .i_w_ena(i_w_ena), .i_w_addr(i_w_addr), .i_w_data(i_w_data),
    .i_push(i_push), .i_pop(i_pop), .o_a_data(o_a_data), .o_b_data(o_b_data),
    .o_level(o_level), .o_full(o_full), .o_empty(o_empty), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given controls, inputs idle again afterwards
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic psh, input logic pp);
    @(negedge i_clk);
    i_w_ena = we; i_w_addr = wa; i_w_data = wd; i_push = psh; i_pop = pp;
    @(negedge i_clk);
    i_w_ena = 1'b0; i_push = 1'b0; i_pop = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b,
                    input logic [31:0] ea, input logic [31:0] eb, input string tag);
    i_a_addr = a; i_b_addr = b;
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    #1;
    check({tag, "_a"}, o_a_data, exp_q.pop_front());
    check({tag, "_b"}, o_b_data, exp_q.pop_front());
  endtask

  task automatic status(input string tag, input int lvl, input logic full,
                        input logic empty, input logic err);
    check({tag, "_level"}, 32'(o_level), 32'(lvl));
    check({tag, "_full"},  32'(o_full),  32'(full));
    check({tag, "_empty"}, 32'(o_empty), 32'(empty));
    check({tag, "_err"},   32'(o_err),   32'(err));
  endtask

  task automatic do_reset();
    @(negedge i_clk); i_reset = 1'b0;
    @(negedge i_clk); i_reset = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    status("reset", 0, 1'b0, 1'b1, 1'b0);
    rd(5'd1, 5'd2, 32'd0, 32'd0, "reset_rd");
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;

    // Basic writes and a disabled write
    cyc(1'b1, 5'd1, 32'd10, 1'b0, 1'b0);
    cyc(1'b1, 5'd2, 32'd1000, 1'b0, 1'b0);
    rd(5'd1, 5'd2, 32'd10, 32'd1000, "wr_basic");
    cyc(1'b0, 5'd2, 32'd2000, 1'b0, 1'b0);
    rd(5'd2, 5'd1, 32'd1000, 32'd10, "wr_disabled");

    // Push isolates banked r1, pop restores it
    cyc(1'b1, 5'd1, 32'd100, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    rd(5'd1, 5'd2, 32'd0, 32'd0, "push_iso");
    status("push1", 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd1, 32'd55, 1'b0, 1'b0);
    rd(5'd1, 5'd0, 32'd55, 32'd0, "lvl1_wr");
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    rd(5'd1, 5'd2, 32'd100, 32'd1000, "pop_restore");
    status("pop1", 0, 1'b0, 1'b1, 1'b0);

    // Shared r5 survives push; r0 stays zero
    cyc(1'b1, 5'd5, 32'd7, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    rd(5'd5, 5'd1, 32'd7, 32'd0, "shared_r5");
    cyc(1'b1, 5'd0, 32'd9, 1'b0, 1'b0);
    rd(5'd0, 5'd5, 32'd0, 32'd7, "x0");
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // Write together with push lands in the old level
    cyc(1'b1, 5'd3, 32'd42, 1'b1, 1'b0);
    rd(5'd3, 5'd1, 32'd0, 32'd0, "wr_push_new");
    status("wr_push", 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    rd(5'd3, 5'd1, 32'd42, 32'd100, "wr_push_old");

    // Push and pop together
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    status("push_pop", 0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle
    @(negedge i_clk);
    #3 i_reset = 1'b0;
    #1;
    status("mid_reset", 0, 1'b0, 1'b1, 1'b0);
    rd(5'd1, 5'd5, 32'd0, 32'd0, "mid_reset_rd");
    @(negedge i_clk); i_reset = 1'b1;

    // Fill the stack, then overflow
    cyc(1'b1, 5'd1, 32'd11, 1'b1, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    status("push2", 2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    status("full", 3, 1'b1, 1'b0, 1'b0);
    rd(5'd1, 5'd0, 32'd0, 32'd0, "full_rd");
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    status("overflow", 3, 1'b1, 1'b0, 1'b1);

    // Underflow after reset
    do_reset();
    status("post_reset", 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    status("underflow", 0, 1'b0, 1'b1, 1'b1);

    // Same-cycle forwarding (or its absence) on both ports
    do_reset();
    @(negedge i_clk);
    i_a_addr = 5'd4; i_b_addr = 5'd4;
    i_w_ena = 1'b1; i_w_addr = 5'd4; i_w_data = 32'd77;
    exp_q.push_back(BYP_EXP);
    exp_q.push_back(BYP_EXP);
    #1;
    check("bypass_same_a", o_a_data, exp_q.pop_front());
    check("bypass_same_b", o_b_data, exp_q.pop_front());
    @(negedge i_clk);
    i_w_ena = 1'b0;
    rd(5'd4, 5'd4, 32'd77, 32'd77, "bypass_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
